// File: rtl/serial_interp_fir_if.sv
// Stream and coefficient-port bundle for serial_interp_fir.
// Handshake rule: a word moves on a clk edge where valid && ready; valid holds its payload until then.
interface serial_interp_fir_if #(
    parameter int L  = 4,
    parameter int T  = 6,
    parameter int DW = 8,
    parameter int CW = 8,
    parameter int OW = 16
);
    localparam int PW = (L > 1) ? $clog2(L) : 1;
    localparam int AW = (L * T > 1) ? $clog2(L * T) : 1;

    logic signed [DW-1:0] x;
    logic                 x_valid;
    logic                 x_ready;
    logic signed [OW-1:0] y;
    logic                 y_valid;
    logic                 y_ready;
    logic [PW-1:0]        y_phase;
    logic                 coef_we;
    logic [AW-1:0]        coef_addr;
    logic signed [CW-1:0] coef_data;

    modport master (
        output x, x_valid, y_ready, coef_we, coef_addr, coef_data,
        input  x_ready, y, y_valid, y_phase
    );

    modport slave (
        input  x, x_valid, y_ready, coef_we, coef_addr, coef_data,
        output x_ready, y, y_valid, y_phase
    );
endinterface

// File: rtl/serial_interp_fir.sv
// Polyphase interpolating FIR with one shared multiplier: each accepted sample yields L
// outputs, phase p computed as sum over k of d[k]*h[k*L+p], one product per clock.
module serial_interp_fir #(
    parameter int L  = 4,
    parameter int T  = 6,
    parameter int DW = 8,
    parameter int CW = 8,
    parameter int OW = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    serial_interp_fir_if.slave   bus,
    output logic [1:0]           dbg_state
);
    localparam int N     = L * T;
    localparam int PW    = (L > 1) ? $clog2(L) : 1;
    localparam int KW    = (T > 1) ? $clog2(T) : 1;
    localparam int AW    = (N > 1) ? $clog2(N) : 1;
    localparam int ACC_W = DW + CW + $clog2(T);

    localparam logic [KW-1:0] K_LAST = KW'(T - 1);
    localparam logic [PW-1:0] P_LAST = PW'(L - 1);
    localparam logic [AW:0]   N_W    = (AW + 1)'(N);
    localparam logic signed [ACC_W-1:0] Y_MAX = ACC_W'(2 ** (OW - 1) - 1);
    localparam logic signed [ACC_W-1:0] Y_MIN = ~Y_MAX;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MAC  = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic signed [DW-1:0]    d [T];
    logic signed [CW-1:0]    h [N];
    logic signed [ACC_W-1:0] acc;
    logic signed [OW-1:0]    y_q;
    logic                    y_valid_q;
    logic [PW-1:0]           y_phase_q;
    logic [PW-1:0]           p;
    logic [KW-1:0]           k;

    logic [AW-1:0]           h_idx;
    logic signed [DW-1:0]    d_sel;
    logic signed [CW-1:0]    h_sel;
    logic signed [DW+CW-1:0] prod;
    logic signed [ACC_W-1:0] mac_sum;
    logic signed [OW-1:0]    y_sat;
    logic                    coef_ok;

    assign bus.x_ready = (state_q == S_IDLE);
    assign bus.y       = y_q;
    assign bus.y_valid = y_valid_q;
    assign bus.y_phase = y_phase_q;
    assign dbg_state   = state_q;

    always_ff @(posedge clk) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (bus.x_valid) state_d = S_MAC;
            S_MAC:  if (k == K_LAST) state_d = S_OUT;
            S_OUT:  if (bus.y_ready) state_d = (p == P_LAST) ? S_IDLE : S_MAC;
            default: state_d = S_IDLE;
        endcase
    end

    // Tap k of phase p lives at h[k*L+p]; the accumulator restarts on k==0.
    always_comb begin
        h_idx   = AW'(k) * AW'(L) + AW'(p);
        d_sel   = d[k];
        h_sel   = h[h_idx];
        prod    = d_sel * h_sel;
        mac_sum = ((k == '0) ? '0 : acc) + ACC_W'(prod);
        if (mac_sum > Y_MAX)      y_sat = Y_MAX[OW-1:0];
        else if (mac_sum < Y_MIN) y_sat = Y_MIN[OW-1:0];
        else                      y_sat = mac_sum[OW-1:0];
        coef_ok = ({1'b0, bus.coef_addr} < N_W);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < T; i++) d[i] <= '0;
            for (int i = 0; i < N; i++) h[i] <= '0;
            acc       <= '0;
            y_q       <= '0;
            y_valid_q <= 1'b0;
            y_phase_q <= '0;
            p         <= '0;
            k         <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.coef_we && coef_ok) h[bus.coef_addr] <= bus.coef_data;
                    if (bus.x_valid) begin
                        d[0] <= bus.x;
                        for (int i = T - 1; i > 0; i--) d[i] <= d[i-1];
                        p <= '0;
                        k <= '0;
                    end
                end
                S_MAC: begin
                    acc <= mac_sum;
                    k   <= k + 1'b1;
                    if (k == K_LAST) begin
                        y_q       <= y_sat;
                        y_phase_q <= p;
                        y_valid_q <= 1'b1;
                    end
                end
                S_OUT: begin
                    if (bus.y_ready) begin
                        y_valid_q <= 1'b0;
                        if (p != P_LAST) begin
                            p <= p + 1'b1;
                            k <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_interp_fir.sv
// Bench for serial_interp_fir: scenario tasks against a sum-of-products model of the
// polyphase filter (history of the last T inputs, coefficient table, clamp).
module tb_serial_interp_fir;
  localparam int L = 4, T = 6, DW = 8, CW = 8, OW = 16;
  localparam int N = L * T;
  localparam int PW = 2, AW = 5, EW = PW + OW;
  localparam int BUDGET = 200;

  logic clk, rst;
  logic [1:0] dbg_state;
  serial_interp_fir_if #(.L(L), .T(T), .DW(DW), .CW(CW), .OW(OW)) bus ();

  serial_interp_fir #(.L(L), .T(T), .DW(DW), .CW(CW), .OW(OW)) dut (
    .clk(clk), .rst(rst), .bus(bus), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;

  // scoreboard state
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] got_q[$];
  logic [19:0]   hold_q[$];
  int            acc_q[$];
  int            stim_q[$];
  int            m_h[N];
  int            m_hist[T];
  int            vectors = 0, miscompares = 0;
  int            first_wait, hold_at;
  bit            timeout;

  function automatic void model_reset();
    for (int i = 0; i < N; i++) m_h[i] = 0;
    for (int i = 0; i < T; i++) m_hist[i] = 0;
    exp_q.delete(); got_q.delete(); hold_q.delete(); acc_q.delete();
    first_wait = -1; hold_at = -1; timeout = 0;
  endfunction

  function automatic void model_push(input int xv);
    int s;
    logic [EW-1:0] e;
    for (int i = T - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
    m_hist[0] = xv;
    for (int ph = 0; ph < L; ph++) begin
      s = 0;
      for (int tap = 0; tap < T; tap++) s += m_hist[tap] * m_h[tap*L + ph];
      if (s > 32767) s = 32767;
      if (s < -32768) s = -32768;
      e = {PW'(ph), OW'(s)};
      exp_q.push_back(e);
    end
  endfunction

  // driver tasks
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic apply_reset();
    rst = 1'b0; bus.x_valid = 1'b0; bus.y_ready = 1'b0; bus.coef_we = 1'b0;
    tick(); tick();
    rst = 1'b1;
    model_reset();
  endtask

  task automatic write_coef(input int a, input int dv);
    bus.coef_we = 1'b1; bus.coef_addr = AW'(a); bus.coef_data = CW'(dv);
    tick();
    bus.coef_we = 1'b0;
    if (a < N) m_h[a] = dv;
  endtask

  task automatic load_ramp();
    for (int n = 0; n < N; n++) write_coef(n, n + 1);
  endtask

  task automatic send_x(input int v);
    int w = 0;
    bus.x = DW'(v); bus.x_valid = 1'b1;
    while (!bus.x_ready && w < BUDGET) begin tick(); w++; end
    if (w >= BUDGET) begin timeout = 1; bus.x_valid = 1'b0; return; end
    tick();
    bus.x_valid = 1'b0;
    acc_q.push_back(cyc);
    model_push(v);
  endtask

  task automatic collect_y(input int n, input int stall_pct);
    for (int i = 0; i < n; i++) begin
      int w = 0;
      forever begin
        if (first_wait < 0 && bus.y_valid) first_wait = w;
        if (bus.y_valid && got_q.size() == hold_at && hold_q.size() == 0) begin
          bus.y_ready = 1'b0;
          repeat (10) begin
            tick();
            hold_q.push_back({bus.x_ready, bus.y_valid, bus.y_phase, bus.y});
          end
        end
        bus.y_ready = ($urandom_range(0, 99) >= stall_pct);
        if (bus.y_valid && bus.y_ready) begin
          got_q.push_back({bus.y_phase, bus.y});
          tick();
          break;
        end
        tick(); w++;
        if (w > BUDGET) begin timeout = 1; return; end
      end
    end
  endtask

  task automatic drive_stream(input int stall_pct);
    foreach (stim_q[i]) begin
      send_x(stim_q[i]);
      if (timeout) return;
      collect_y(L, stall_pct);
      if (timeout) return;
    end
  endtask

  // scenarios
  task automatic test_reset();
    apply_reset();
    vectors++; if (bus.y !== 16'sd0) begin miscompares++; $display("FAIL reset_y: got %0d want 0", bus.y); end
    vectors++; if (bus.y_valid !== 1'b0) begin miscompares++; $display("FAIL reset_y_valid: got %b want 0", bus.y_valid); end
    vectors++; if (bus.x_ready !== 1'b1) begin miscompares++; $display("FAIL reset_x_ready: got %b want 1", bus.x_ready); end
    vectors++; if (bus.y_phase !== 2'd0) begin miscompares++; $display("FAIL reset_y_phase: got %0d want 0", bus.y_phase); end
    tick();
    vectors++; if (bus.x_ready !== 1'b1 || bus.y_valid !== 1'b0) begin
      miscompares++; $display("FAIL reset_idle_hold: x_ready=%b y_valid=%b want 1 0", bus.x_ready, bus.y_valid);
    end
  endtask

  task automatic test_impulse();
    logic [EW-1:0] e;
    apply_reset(); load_ramp();
    stim_q = '{1, 0, 0, 0, 0, 0};
    drive_stream(0);
    vectors++; if (timeout || got_q.size() != N) begin
      miscompares++; $display("FAIL impulse_count: got %0d outputs timeout=%0d want %0d", got_q.size(), timeout, N);
    end
    for (int i = 0; i < got_q.size() && i < N; i++) begin
      e = {PW'(i % L), OW'(i + 1)};
      vectors++; if (got_q[i] !== e) begin
        miscompares++; $display("FAIL impulse_y[%0d]: got %h want %h", i, got_q[i], e);
      end
    end
    vectors++; if (first_wait != T) begin
      miscompares++; $display("FAIL impulse_latency: got %0d want %0d", first_wait, T);
    end
    vectors++; if (acc_q.size() < 2 || acc_q[1] - acc_q[0] != L*(T+1)+1) begin
      miscompares++; $display("FAIL impulse_period: got %0d want %0d", (acc_q.size() < 2) ? -1 : acc_q[1] - acc_q[0], L*(T+1)+1);
    end
  endtask

  task automatic test_backpressure();
    logic [EW-1:0] e;
    logic [19:0]   he;
    apply_reset(); load_ramp();
    hold_at = 1;
    stim_q = '{1, 0, 0, 0, 0, 0};
    drive_stream(0);
    hold_at = -1;
    he = {1'b0, 1'b1, 2'd1, 16'd2};
    vectors++; if (hold_q.size() != 10) begin
      miscompares++; $display("FAIL stall_len: got %0d want 10", hold_q.size());
    end
    foreach (hold_q[i]) begin
      vectors++; if (hold_q[i] !== he) begin
        miscompares++; $display("FAIL stall_hold[%0d]: got %h want %h", i, hold_q[i], he);
      end
    end
    vectors++; if (timeout || got_q.size() != N) begin
      miscompares++; $display("FAIL stall_count: got %0d want %0d", got_q.size(), N);
    end
    for (int i = 0; i < got_q.size() && i < N; i++) begin
      e = {PW'(i % L), OW'(i + 1)};
      vectors++; if (got_q[i] !== e) begin
        miscompares++; $display("FAIL stall_y[%0d]: got %h want %h", i, got_q[i], e);
      end
    end
  endtask

  task automatic test_saturation();
    logic [EW-1:0] e;
    apply_reset();
    for (int n = 0; n < N; n++) write_coef(n, 127);
    stim_q = '{127, 127, 127, 127, 127, 127};
    drive_stream(0);
    stim_q = '{-128, -128, -128, -128, -128, -128};
    drive_stream(0);
    vectors++; if (timeout || got_q.size() != 2*N || exp_q.size() != 2*N) begin
      miscompares++; $display("FAIL sat_count: got %0d want %0d", got_q.size(), 2*N);
    end
    for (int i = 0; i < L && got_q.size() == 2*N; i++) begin
      e = {PW'(i), 16'h7fff};
      vectors++; if (got_q[N-L+i] !== e) begin
        miscompares++; $display("FAIL sat_pos[%0d]: got %h want %h", i, got_q[N-L+i], e);
      end
      e = {PW'(i), 16'h8000};
      vectors++; if (got_q[2*N-L+i] !== e) begin
        miscompares++; $display("FAIL sat_neg[%0d]: got %h want %h", i, got_q[2*N-L+i], e);
      end
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      vectors++; if (got_q[i] !== exp_q[i]) begin
        miscompares++; $display("FAIL sat_model[%0d]: got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_write_gating();
    logic [EW-1:0] e;
    apply_reset();
    for (int n = 0; n < N; n++) write_coef(n, 1);
    send_x(1);
    tick(); tick();
    bus.coef_we = 1'b1; bus.coef_addr = '0; bus.coef_data = 8'sd50;
    tick();
    bus.coef_we = 1'b0;
    collect_y(L, 0);
    send_x(1);
    collect_y(L, 0);
    write_coef(0, 50);
    send_x(1);
    collect_y(L, 0);
    vectors++; if (timeout || got_q.size() != 3*L) begin
      miscompares++; $display("FAIL gate_count: got %0d want %0d", got_q.size(), 3*L);
    end
    for (int i = 0; i < L && got_q.size() == 3*L; i++) begin
      e = {PW'(i), 16'd1};
      vectors++; if (got_q[i] !== e) begin
        miscompares++; $display("FAIL gate_mac_write[%0d]: got %h want %h", i, got_q[i], e);
      end
    end
    e = {2'd0, 16'd2};
    vectors++; if (got_q.size() > L && got_q[L] !== e) begin
      miscompares++; $display("FAIL gate_ignored: got %h want %h", got_q[L], e);
    end
    e = {2'd0, 16'd52};
    vectors++; if (got_q.size() > 2*L && got_q[2*L] !== e) begin
      miscompares++; $display("FAIL gate_idle_write: got %h want %h", got_q[2*L], e);
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      vectors++; if (got_q[i] !== exp_q[i]) begin
        miscompares++; $display("FAIL gate_model[%0d]: got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [EW-1:0] e;
    apply_reset(); load_ramp();
    send_x(5);
    collect_y(2, 0);
    tick(); tick();
    rst = 1'b0;
    tick();
    vectors++; if (bus.y_valid !== 1'b0 || bus.x_ready !== 1'b1) begin
      miscompares++; $display("FAIL midreset_flags: y_valid=%b x_ready=%b want 0 1", bus.y_valid, bus.x_ready);
    end
    vectors++; if (bus.y !== 16'sd0 || bus.y_phase !== 2'd0) begin
      miscompares++; $display("FAIL midreset_y: y=%0d phase=%0d want 0 0", bus.y, bus.y_phase);
    end
    rst = 1'b1;
    model_reset();
    load_ramp();
    stim_q = '{1, 0, 0, 0, 0, 0};
    drive_stream(0);
    vectors++; if (timeout || got_q.size() != N) begin
      miscompares++; $display("FAIL midreset_count: got %0d want %0d", got_q.size(), N);
    end
    for (int i = 0; i < got_q.size() && i < N; i++) begin
      e = {PW'(i % L), OW'(i + 1)};
      vectors++; if (got_q[i] !== e) begin
        miscompares++; $display("FAIL midreset_y[%0d]: got %h want %h", i, got_q[i], e);
      end
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int n = 0; n < N; n++) write_coef(n, int'($urandom_range(0, 255)) - 128);
    write_coef(N + int'($urandom_range(0, 7)), int'($urandom_range(0, 255)) - 128);
    stim_q.delete();
    for (int i = 0; i < 20; i++) stim_q.push_back(int'($urandom_range(0, 255)) - 128);
    drive_stream(30);
    vectors++; if (timeout || got_q.size() != exp_q.size()) begin
      miscompares++; $display("FAIL rand_count: got %0d want %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      vectors++; if (got_q[i] !== exp_q[i]) begin
        miscompares++; $display("FAIL rand_y[%0d]: got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; bus.x = '0; bus.x_valid = 1'b0; bus.y_ready = 1'b0;
    bus.coef_we = 1'b0; bus.coef_addr = '0; bus.coef_data = '0;
    test_reset();
    test_impulse();
    test_backpressure();
    test_saturation();
    test_write_gating();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
